// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
//
// Round-robin arbiter that shares one 4:1 single-bit mux among four
// requesters. Each requester owns one mux input (A..D). The arbiter drives
// the mux select pair {S,T} = sel and grants one requester at a time. A
// requester may hold the grant for at most MAX_HOLD consecutive cycles while
// someone else is waiting. The selected data bit is registered onto dout.
//
// Handshake: req[i] is a level request. Requester i owns the shared mux
// input while grant[i]=1. It keeps ownership for as long as it holds req[i],
// unless it is preempted after MAX_HOLD cycles by another waiting requester.
// Dropping req[i] hands the mux to the next waiting requester on the same
// edge, with no idle cycle in between.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   req    in   4  request lines (bit0=A owner .. bit3=D owner)
//   din    in   4  mux data inputs (din[0]=A .. din[3]=D)
//   grant  out  4  registered one-hot grant; zero when idle
//   sel    out  2  registered {S,T} select; index of current/last grantee
//   busy   out  1  high while a grant is active
//   dout   out  1  registered din[sel] while busy; 0 when idle
//
// Internal state is held in state_q (IDLE/GRANT), cnt_q (hold counter) and
// last_q (last winner, the round-robin pointer).
// ---------------------------------------------------------------------------
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout
);

  localparam logic [3:0] MAX_HOLD_C = MAX_HOLD[3:0];

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic       dout_q,  dout_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] last_q,  last_d;

  // Round-robin search: returns {found, index}. Scans base+1, base+2,
  // base+3, base (mod 4) and takes the first set bit.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (r[idx] && !res[2]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Shared decode used by both the next-state and the output logic.
  logic [1:0] owner;
  logic [3:0] owner_oh;
  logic [3:0] others;
  logic [2:0] idle_pick;
  logic [2:0] hand_pick;
  logic       owner_req;
  logic       at_max;
  logic       start_grant;
  logic       switch_now;
  logic       release_idle;

  always_comb begin
    owner        = sel_q;
    owner_oh     = 4'b0001 << owner;
    others       = req & ~owner_oh;
    idle_pick    = rr_pick(req, last_q);
    // Handoff search starts after the current owner, with its bit masked.
    hand_pick    = rr_pick(others, owner);
    owner_req    = req[owner];
    at_max       = (cnt_q == MAX_HOLD_C);
    start_grant  = (state_q == ST_IDLE) && idle_pick[2];
    // Release with a waiter, or preemption once the hold limit is reached.
    switch_now   = (state_q == ST_GRANT) && (!owner_req || at_max) && hand_pick[2];
    release_idle = (state_q == ST_GRANT) && !owner_req && !hand_pick[2];
  end

  // State register (all flops, async reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= 4'd0;
      last_q  <= 2'd3;   // index 0 gets first priority after reset
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (start_grant)  state_d = ST_GRANT;
    if (release_idle) state_d = ST_IDLE;
  end

  // Output / datapath next values.
  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (start_grant) begin
      grant_d = 4'b0001 << idle_pick[1:0];
      sel_d   = idle_pick[1:0];
      busy_d  = 1'b1;
      cnt_d   = 4'd1;
      last_d  = idle_pick[1:0];
    end else if (switch_now) begin
      grant_d = 4'b0001 << hand_pick[1:0];
      sel_d   = hand_pick[1:0];
      busy_d  = 1'b1;
      cnt_d   = 4'd1;
      last_d  = hand_pick[1:0];
    end else if (release_idle) begin
      // sel keeps the last grantee so the mux select does not move.
      grant_d = 4'b0000;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if ((state_q == ST_GRANT) && !at_max) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Uses the registered select, so dout trails a grant switch by a cycle.
    dout_d = busy_q ? din[sel_q] : 1'b0;
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
module tb_rr_mux4_arbiter;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       dout;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .dout  (dout)
  );

  initial begin
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin
      $display("FAIL param: MAX_HOLD=%0d outside 1..15", MAX_HOLD);
      $fatal(1);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle 1 time unit past it; inputs are driven here too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset state, checked while reset is still asserted
    #3;
    chk("rst_grant", {28'd0, grant}, 32'h0);
    chk("rst_sel",   {30'd0, sel},   32'h0);
    chk("rst_busy",  {31'd0, busy},  32'h0);
    chk("rst_dout",  {31'd0, dout},  32'h0);
    do_reset();

    // Test 1: first grant, dout tracks din[0] one cycle late
    req = 4'b0001;
    step();
    chk("t1_grant", {28'd0, grant}, 32'h1);
    chk("t1_sel",   {30'd0, sel},   32'h0);
    chk("t1_busy",  {31'd0, busy},  32'h1);
    chk("t1_dout0", {31'd0, dout},  32'h0);
    din = 4'b0001;
    step();
    chk("t1_dout1", {31'd0, dout}, 32'h1);
    din = 4'b0000;
    step();
    chk("t1_dout2", {31'd0, dout}, 32'h0);
    din = 4'b0001;
    step();
    chk("t1_dout3", {31'd0, dout}, 32'h1);
    req = 4'b0000;
    step();
    chk("t1_rel_grant", {28'd0, grant}, 32'h0);
    chk("t1_rel_busy",  {31'd0, busy},  32'h0);
    chk("t1_rel_sel",   {30'd0, sel},   32'h0);
    step();
    chk("t1_idle_dout", {31'd0, dout}, 32'h0);

    // Test 2: full contention from reset, 4-cycle slots 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4 * MAX_HOLD + 4; i++) exp_q.push_back(4'b0001 << ((i / MAX_HOLD) % 4));
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      step();
      chk($sformatf("t2_grant_%0d", i), {28'd0, grant}, {28'd0, e});
      chk($sformatf("t2_sel_%0d", i),   {28'd0, 2'b00, sel}, 32'((i / MAX_HOLD) % 4));
    end

    // Test 3: owner 2 drops with owner 3 waiting -> immediate handoff
    do_reset();
    req = 4'b0100;
    step();
    chk("t3_grant2", {28'd0, grant}, 32'h4);
    req = 4'b1100;
    din = 4'b1000;
    step();
    chk("t3_hold2", {28'd0, grant}, 32'h4);
    req = 4'b1000;
    step();
    chk("t3_hand_grant", {28'd0, grant}, 32'h8);
    chk("t3_hand_sel",   {30'd0, sel},   32'h3);
    chk("t3_hand_busy",  {31'd0, busy},  32'h1);
    chk("t3_hand_cnt",   {28'd0, dut.cnt_q}, 32'h1);
    chk("t3_dout_lag",   {31'd0, dout},  32'h0);
    step();
    chk("t3_dout_d3", {31'd0, dout}, 32'h1);

    // Test 4: sole owner 1 releases to idle, then 0011 picks 0
    do_reset();
    req = 4'b0010;
    din = 4'b0010;
    step();
    chk("t4_grant1", {28'd0, grant}, 32'h2);
    step();
    chk("t4_dout1", {31'd0, dout}, 32'h1);
    req = 4'b0000;
    step();
    chk("t4_idle_grant", {28'd0, grant}, 32'h0);
    chk("t4_idle_busy",  {31'd0, busy},  32'h0);
    chk("t4_idle_sel",   {30'd0, sel},   32'h1);
    step();
    chk("t4_idle_dout", {31'd0, dout}, 32'h0);
    req = 4'b0011;
    step();
    chk("t4_rr_grant", {28'd0, grant}, 32'h1);
    chk("t4_rr_sel",   {30'd0, sel},   32'h0);

    // Test 5: lone requester 3 saturates, then 0 preempts
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("t5_hold_%0d", i), {28'd0, grant}, 32'h8);
    end
    chk("t5_cnt_sat", {28'd0, dut.cnt_q}, 32'(MAX_HOLD));
    req = 4'b1001;
    step();
    chk("t5_preempt", {28'd0, grant}, 32'h1);
    chk("t5_pre_cnt", {28'd0, dut.cnt_q}, 32'h1);

    // Test 6: async reset between edges while owner 2 holds the mux
    do_reset();
    req = 4'b0100;
    din = 4'b0100;
    step();
    step();
    chk("t6_pre_grant", {28'd0, grant}, 32'h4);
    chk("t6_pre_dout",  {31'd0, dout},  32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_grant", {28'd0, grant}, 32'h0);
    chk("t6_async_sel",   {30'd0, sel},   32'h0);
    chk("t6_async_busy",  {31'd0, busy},  32'h0);
    chk("t6_async_dout",  {31'd0, dout},  32'h0);
    #1;
    rst = 1'b0;
    step();
    chk("t6_regrant", {28'd0, grant}, 32'h4);
    chk("t6_resel",   {30'd0, sel},   32'h2);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
